// File: rtl/mem_tile_arbiter_if.sv
// Requester/tile bundle for the memory tile arbiter.
// master: the arbiter itself. slave: the environment (requesters + tile).
interface mem_tile_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 256
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_write;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                 req_ready;

    logic                               mem_rd;
    logic                               mem_wr;
    logic [ADDR_WIDTH-1:0]              mem_addr;
    logic [DATA_WIDTH-1:0]              mem_wdata;
    logic                               mem_ack;
    logic [DATA_WIDTH-1:0]              mem_rdata;

    logic [NUM_REQ-1:0]                 rsp_valid;
    logic [DATA_WIDTH-1:0]              rsp_rdata;
    logic                               rsp_err;
    logic                               busy;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, mem_rd, mem_wr, mem_addr, mem_wdata,
               rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, mem_rd, mem_wr, mem_addr, mem_wdata,
               rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/mem_tile_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters one outstanding access at a
// time to a wide memory tile, with a BUSY-phase timeout.
module mem_tile_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned TIMEOUT    = 16
) (
    input logic                clk,
    input logic                rst_n,
    mem_tile_arbiter_if.master bus
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]       win_q, win_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  grant_any;
    logic [IdxW-1:0]       grant_idx;
    logic                  leave_busy;

    // (base + off) mod NUM_REQ; both operands are already below NUM_REQ.
    function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                                 input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IdxW'(sum);
    endfunction

    // Pick the first valid requester at or after rr_ptr, wrapping upward.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && bus.req_valid[wrap_add(rr_ptr_q, i)]) begin
                grant_any = 1'b1;
                grant_idx = wrap_add(rr_ptr_q, i);
            end
        end
    end

    // Next-state logic: accept in IDLE, wait for ack or timeout in BUSY, one-cycle RESP.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        leave_busy  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_any) begin
                    win_d    = grant_idx;
                    mem_rd_d = !bus.req_write[grant_idx];
                    mem_wr_d = bus.req_write[grant_idx];
                    addr_d   = bus.req_addr[grant_idx];
                    wdata_d  = bus.req_wdata[grant_idx];
                    cnt_d    = '0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (bus.mem_ack) begin
                    rsp_rdata_d = mem_wr_q ? '0 : bus.mem_rdata;
                    rsp_err_d   = 1'b0;
                    leave_busy  = 1'b1;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    leave_busy  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (leave_busy) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    addr_d   = '0;
                    wdata_d  = '0;
                    state_d  = StResp;
                end
            end
            StResp: begin
                rr_ptr_d = wrap_add(win_q, 32'd1);
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and latched-request registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = (state_q == StIdle && grant_any) ? NUM_REQ'(1) << grant_idx : '0;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rsp_valid = (state_q == StResp) ? NUM_REQ'(1) << win_q : '0;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_mem_tile_arbiter.sv
// Self-checking bench for mem_tile_arbiter: directed vector table, corner
// sequences, and randomized traffic against a transaction-level model.
module tb_mem_tile_arbiter;
    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 256;
    localparam int unsigned TIMEOUT    = 16;
    localparam logic [DATA_WIDTH-1:0] A5 = {32{8'hA5}};

    localparam int PhIdle = 0;
    localparam int PhBusy = 1;
    localparam int PhResp = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_tile_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH),
                          .DATA_WIDTH(DATA_WIDTH)) bus ();

    mem_tile_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH),
                       .DATA_WIDTH(DATA_WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: phase, owner and latched transfer.
    int                    m_phase;
    int                    m_ptr;
    int                    m_owner;
    int                    m_elapsed;
    logic                  m_write;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic                  m_err;

    logic [NUM_REQ-1:0]    e_ready, e_rsp;
    logic                  e_rd, e_wr, e_busy;
    logic [ADDR_WIDTH-1:0] e_addr;
    logic [DATA_WIDTH-1:0] e_wdata;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic [3:0] write;
        logic       ack;
        logic [3:0] ready;
        logic       rd;
        logic       wr;
        logic [3:0] rsp;
        logic       busy;
        logic       a5;
    } vec_t;
    vec_t tbl [20];

    task automatic cmp(input string name, input logic [DATA_WIDTH-1:0] act,
                       input logic [DATA_WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_WIDTH-1:0] rand_data();
        logic [DATA_WIDTH-1:0] d;
        for (int i = 0; i < DATA_WIDTH / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // Winner = valid requester with the smallest upward distance from ptr.
    function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
        int best;
        int best_dist;
        int d;
        best      = -1;
        best_dist = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = (i - ptr + NUM_REQ) % NUM_REQ;
            if (v[i] && d < best_dist) begin
                best_dist = d;
                best      = i;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_phase = PhIdle; m_ptr = 0; m_owner = 0; m_elapsed = 0;
        m_write = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
    endtask

    task automatic model_expect();
        int w;
        e_ready = '0; e_rsp = '0; e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0;
        e_addr = '0; e_wdata = '0;
        if (m_phase == PhIdle) begin
            w = pick(bus.req_valid, m_ptr);
            if (w >= 0) e_ready[w] = 1'b1;
        end else if (m_phase == PhBusy) begin
            e_rd = !m_write; e_wr = m_write; e_addr = m_addr; e_wdata = m_wdata;
            e_busy = 1'b1;
        end else begin
            e_rsp[m_owner] = 1'b1;
            e_busy = 1'b1;
        end
    endtask

    task automatic model_advance();
        int w;
        if (m_phase == PhIdle) begin
            w = pick(bus.req_valid, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_write = bus.req_write[w]; m_addr = bus.req_addr[w];
                m_wdata = bus.req_wdata[w]; m_elapsed = 0; m_phase = PhBusy;
            end
        end else if (m_phase == PhBusy) begin
            m_elapsed++;
            if (bus.mem_ack) begin
                m_rdata = m_write ? '0 : bus.mem_rdata; m_err = 1'b0; m_phase = PhResp;
            end else if (m_elapsed == TIMEOUT) begin
                m_rdata = '0; m_err = 1'b1; m_phase = PhResp;
            end
        end else begin
            m_ptr = (m_owner + 1) % NUM_REQ;
            m_phase = PhIdle;
        end
    endtask

    // Inputs are driven at posedge+1; outputs are checked at posedge+4.
    task automatic settle_check(input string tag);
        #3;
        model_expect();
        cmp({tag, ".ready"}, bus.req_ready, e_ready);
        cmp({tag, ".mem_rd"}, bus.mem_rd, e_rd);
        cmp({tag, ".mem_wr"}, bus.mem_wr, e_wr);
        cmp({tag, ".mem_addr"}, bus.mem_addr, e_addr);
        cmp({tag, ".mem_wdata"}, bus.mem_wdata, e_wdata);
        cmp({tag, ".rsp_valid"}, bus.rsp_valid, e_rsp);
        cmp({tag, ".busy"}, bus.busy, e_busy);
        cmp({tag, ".rsp_rdata"}, bus.rsp_rdata, m_rdata);
        cmp({tag, ".rsp_err"}, bus.rsp_err, m_err);
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Run idle cycles with ack high until the model is back in IDLE.
    task automatic drain(input string tag);
        bus.req_valid = '0;
        bus.mem_ack   = 1'b1;
        for (int i = 0; i < 40 && m_phase != PhIdle; i++) begin
            settle_check(tag);
            clock_edge();
        end
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        int   wr_cycles;
        logic seen;
        int   ack_pct;
        logic [DATA_WIDTH-1:0] pat;

        // vectors: rst, valid, write, ack | ready, rd, wr, rsp, busy, rdata==A5
        tbl[0]  = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1};
        tbl[19] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1};

        bus.req_valid = '0;
        bus.req_write = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            bus.req_addr[r]  = ADDR_WIDTH'(32'h1000 * (r + 1));
            bus.req_wdata[r] = rand_data();
        end
        bus.req_addr[1] = 32'h100;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = A5;

        // Reset state.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        cmp("rst.ready", bus.req_ready, '0);
        cmp("rst.mem_rd", bus.mem_rd, '0);
        cmp("rst.mem_wr", bus.mem_wr, '0);
        cmp("rst.mem_addr", bus.mem_addr, '0);
        cmp("rst.mem_wdata", bus.mem_wdata, '0);
        cmp("rst.rsp_valid", bus.rsp_valid, '0);
        cmp("rst.rsp_rdata", bus.rsp_rdata, '0);
        cmp("rst.rsp_err", bus.rsp_err, '0);
        cmp("rst.busy", bus.busy, '0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single read, then round-robin sweep from a fresh reset.
        for (int k = 0; k < 20; k++) begin
            if (tbl[k].rst) do_reset();
            bus.req_valid = tbl[k].valid;
            bus.req_write = tbl[k].write;
            bus.mem_ack   = tbl[k].ack;
            #3;
            cmp($sformatf("tbl%0d.ready", k), bus.req_ready, tbl[k].ready);
            cmp($sformatf("tbl%0d.mem_rd", k), bus.mem_rd, tbl[k].rd);
            cmp($sformatf("tbl%0d.mem_wr", k), bus.mem_wr, tbl[k].wr);
            cmp($sformatf("tbl%0d.rsp_valid", k), bus.rsp_valid, tbl[k].rsp);
            cmp($sformatf("tbl%0d.busy", k), bus.busy, tbl[k].busy);
            cmp($sformatf("tbl%0d.rsp_rdata", k), bus.rsp_rdata, tbl[k].a5 ? A5 : '0);
            cmp($sformatf("tbl%0d.rsp_err", k), bus.rsp_err, '0);
            if (tbl[k].ready == 4'b0010 && k == 0)
                cmp("tbl0.addr_sel", bus.req_addr[1], 32'h100);
            clock_edge();
        end
        drain("drain0");

        // Timeout: write from requester 2, never acked.
        bus.req_valid    = 4'b0100;
        bus.req_write    = 4'b0100;
        bus.req_wdata[2] = rand_data();
        bus.mem_ack      = 1'b0;
        settle_check("to_acc");
        clock_edge();
        bus.req_valid = '0;
        wr_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            settle_check("to_busy");
            if (bus.mem_wr) wr_cycles++;
            if (bus.rsp_valid != '0) begin
                seen = 1'b1;
                cmp("to.rsp_valid", bus.rsp_valid, 4'b0100);
                cmp("to.rsp_err", bus.rsp_err, 1'b1);
                cmp("to.rsp_rdata", bus.rsp_rdata, '0);
            end
            clock_edge();
            if (seen) break;
        end
        cmp("to.rsp_seen", seen, 1'b1);
        cmp("to.wr_cycles", wr_cycles, TIMEOUT);
        drain("drain1");

        // Ack arriving on the last BUSY cycle beats the timeout.
        pat = rand_data();
        bus.mem_rdata = pat;
        bus.req_valid = 4'b0001;
        bus.req_write = 4'b0000;
        settle_check("col_acc");
        clock_edge();
        bus.req_valid = '0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            bus.mem_ack = (k == TIMEOUT);
            settle_check("col_busy");
            if (k == TIMEOUT) cmp("col.mem_rd_last", bus.mem_rd, 1'b1);
            clock_edge();
        end
        bus.mem_ack = 1'b0;
        settle_check("col_resp");
        cmp("col.rsp_valid", bus.rsp_valid, 4'b0001);
        cmp("col.rsp_err", bus.rsp_err, 1'b0);
        cmp("col.rsp_rdata", bus.rsp_rdata, pat);
        clock_edge();
        drain("drain2");

        // Reset in the middle of a requester-3 read.
        bus.req_valid = 4'b1000;
        bus.req_write = 4'b0000;
        bus.mem_ack   = 1'b0;
        settle_check("r3_acc");
        clock_edge();
        bus.req_valid = '0;
        settle_check("r3_busy");
        cmp("r3.mem_rd_before", bus.mem_rd, 1'b1);
        clock_edge();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        cmp("r3.mem_rd_in_rst", bus.mem_rd, 1'b0);
        cmp("r3.busy_in_rst", bus.busy, 1'b0);
        cmp("r3.rsp_in_rst", bus.rsp_valid, '0);
        @(posedge clk);
        #1;
        cmp("r3.rsp_in_rst2", bus.rsp_valid, '0);
        rst_n = 1'b1;
        bus.req_valid = 4'b1111;
        settle_check("r3_after");
        cmp("r3.grant0", bus.req_ready, 4'b0001);
        clock_edge();
        drain("drain3");

        // Address change during BUSY, then spurious ack while idle.
        bus.req_valid   = 4'b0010;
        bus.req_write   = 4'b0000;
        bus.req_addr[1] = 32'h100;
        bus.mem_ack     = 1'b0;
        settle_check("stab_acc");
        clock_edge();
        bus.req_valid   = '0;
        bus.req_addr[1] = 32'hDEAD_BEEF;
        settle_check("stab_b1");
        cmp("stab.mem_addr1", bus.mem_addr, 32'h100);
        clock_edge();
        bus.mem_ack = 1'b1;
        settle_check("stab_b2");
        cmp("stab.mem_addr2", bus.mem_addr, 32'h100);
        clock_edge();
        bus.mem_ack = 1'b0;
        settle_check("stab_resp");
        clock_edge();
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle_check("spur");
            cmp("spur.rsp_valid", bus.rsp_valid, '0);
            cmp("spur.busy", bus.busy, 1'b0);
            clock_edge();
        end
        bus.mem_ack = 1'b0;

        // Randomized traffic against the model.
        ack_pct = 30;
        for (int c = 0; c < 1500; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ack_pct = 3;
                    1:       ack_pct = 30;
                    default: ack_pct = 85;
                endcase
            end
            if ($urandom_range(0, 399) == 0) do_reset();
            bus.req_valid = ($urandom_range(0, 3) == 0) ? '0 : NUM_REQ'($urandom());
            bus.req_write = NUM_REQ'($urandom());
            for (int r = 0; r < NUM_REQ; r++) begin
                bus.req_addr[r]  = $urandom();
                bus.req_wdata[r] = rand_data();
            end
            bus.mem_ack   = ($urandom_range(0, 99) < ack_pct);
            bus.mem_rdata = rand_data();
            settle_check("rnd");
            clock_edge();
        end
        drain("drain4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_tile_arbiter.md
MEM_TILE_ARBITER -- requirements
Module: mem_tile_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, request/tile address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 256, wide data width (8 x 32-bit words).
REQ-004 SHALL have parameter TIMEOUT, default 16, max BUSY cycles awaiting mem_ack (>=2).
REQ-005 SHALL have clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have req_valid  input  NUM_REQ  per-requester request pending.
REQ-008 SHALL have req_write  input  NUM_REQ  per-requester 1=write, 0=read.
REQ-009 SHALL have req_addr  input  NUM_REQ x ADDR_WIDTH  per-requester address.
REQ-010 SHALL have req_wdata  input  NUM_REQ x DATA_WIDTH  per-requester write data.
REQ-011 SHALL have req_ready  output  NUM_REQ  one-hot accept; request transfers when valid&&ready.
REQ-012 SHALL have mem_rd, mem_wr  output  1 each  read/write strobe to tile slave port.
REQ-013 SHALL have mem_addr  output  ADDR_WIDTH; mem_wdata  output  DATA_WIDTH  latched request.
REQ-014 SHALL have mem_ack  input  1; mem_rdata  input  DATA_WIDTH  tile completion and read data.
REQ-015 SHALL have rsp_valid  output  NUM_REQ  one-hot completion pulse to owning requester.
REQ-016 SHALL have rsp_rdata  output  DATA_WIDTH; rsp_err  output  1  shared response data, timeout flag.
REQ-017 SHALL have busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement states IDLE, BUSY, RESP; one outstanding tile access at a time.
REQ-019 IDLE: if any req_valid, winner = first set bit at or after rr_ptr, scanning upward modulo NUM_REQ; req_ready = one-hot(winner), combinational, only in IDLE.
REQ-020 IDLE with no req_valid: req_ready=0, state holds, rr_ptr unchanged.
REQ-021 On accept: latch winner index, req_write, req_addr, req_wdata; next state BUSY; timeout counter cleared to 0.
REQ-022 BUSY: mem_rd=!write_lat, mem_wr=write_lat, registered; first asserted in the cycle after accept, held until mem_ack is sampled.
REQ-023 mem_addr/mem_wdata SHALL equal latched values and stay stable throughout BUSY; both are 0 outside BUSY.
REQ-024 BUSY with mem_ack=1: capture mem_rdata (read) or 0 (write) into rsp_rdata; rsp_err=0; next state RESP.
REQ-025 BUSY with mem_ack=0: counter increments; when counter==TIMEOUT-1, next state RESP with rsp_err=1, rsp_rdata=0.
REQ-026 mem_ack and timeout in the same cycle: ack wins, rsp_err=0.
REQ-027 mem_ack outside BUSY SHALL be ignored; no state or output change.
REQ-028 RESP lasts exactly one cycle: rsp_valid=one-hot(winner); rr_ptr <= (winner+1) mod NUM_REQ; next state IDLE.
REQ-029 rsp_rdata and rsp_err SHALL hold their value until the next RESP.
REQ-030 Minimum accept-to-rsp_valid latency SHALL be 3 cycles (accept, BUSY with ack, RESP); a new accept is possible the cycle after RESP.
REQ-031 Starvation bound: a continuously-valid requester SHALL be granted within NUM_REQ grants.
REQ-032 Requests deasserting before accept SHALL be dropped silently; inputs changing during BUSY SHALL NOT affect the latched access.

Reset
REQ-033 On rst_n low, asynchronously: state=IDLE, rr_ptr=0, counter=0, mem_rd=mem_wr=0, mem_addr=mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
REQ-034 Reset mid-BUSY SHALL abandon the access with no rsp_valid; after release, arbitration restarts from requester 0.

Verification
REQ-035 Single read: req_valid=4'b0010, addr=0x100; mem_ack after 2 BUSY cycles with mem_rdata=0xA5..A5 -> req_ready=0010, mem_rd high 2 cycles, rsp_valid=0010, rsp_rdata=0xA5..A5, rsp_err=0.
REQ-036 Round-robin: req_valid=4'b1111 held, ack each access on first BUSY cycle -> grant order 0,1,2,3,0; rsp_valid each 3 cycles apart.
REQ-037 Timeout: write from requester 2, mem_ack never asserted -> mem_wr high exactly 16 cycles, then rsp_valid=0100, rsp_err=1, rsp_rdata=0.
REQ-038 Ack/timeout collision: mem_ack on 16th BUSY cycle -> rsp_err=0, mem_rdata captured.
REQ-039 Reset mid-BUSY: rst_n low during requester-3 read -> mem_rd=0 immediately, no rsp_valid; after release, req_valid=1111 grants requester 0.
REQ-040 Stability: change req_addr[1] during requester-1 BUSY -> mem_addr unchanged; spurious mem_ack in IDLE -> no rsp_valid.
